// File: rtl/gb_host_seq.sv
// Ghostbus host sequencer: queues WRITE/READ/CHECK/POLL commands and runs them
// one at a time on the ghostbus, reporting one response per command.
`timescale 1ns/1ps
module gb_host_seq #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int TOW    = 12,
  parameter int DEPTH  = 4
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  input  logic [DW-1:0] cmd_mask,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          rsp_to,
  output logic          busy,
  output logic [15:0]   err_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_CK = 2'd2, OP_PL = 2'd3;
  localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_WSTB, S_RSTB, S_RWAIT, S_EVAL, S_DONE} state_t;

  cmd_t          r_mem [DEPTH];
  logic [PW:0]   r_wp, r_rp;
  state_t        r_state;
  logic [1:0]    r_op;
  logic [DW-1:0] r_data, r_mask, r_rdata;
  logic          r_err, r_to;
  logic [2:0]    r_wait;
  logic [TOW-1:0] r_tocnt;

  logic w_empty, w_full, w_push, w_match;
  cmd_t w_head, w_cmd_in;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign w_empty  = (r_wp == r_rp);
  assign w_full   = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_push   = cmd_valid && !w_full;
  assign w_head   = r_mem[r_rp[PW-1:0]];
  assign w_cmd_in = '{op: cmd_op, addr: cmd_addr, data: cmd_data, mask: cmd_mask};
  assign w_match  = ((gb_rdata ^ r_data) & r_mask) == '0;
  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);

  always_ff @(posedge gb_clk) begin
    if (w_push) r_mem[r_wp[PW-1:0]] <= w_cmd_in;
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_state   <= S_IDLE;
      r_op      <= OP_WR;
      r_data    <= '0;
      r_mask    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
      r_wait    <= '0;
      r_tocnt   <= '0;
      gb_addr   <= '0;
      gb_wdata  <= '0;
      gb_wen    <= 1'b0;
      gb_rstb   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_to    <= 1'b0;
      err_count <= '0;
    end else begin
      gb_wen    <= 1'b0;
      gb_rstb   <= 1'b0;
      rsp_valid <= 1'b0;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (r_tocnt != '0) r_tocnt <= r_tocnt - TOW'(1);
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_rp     <= r_rp + 1'b1;
          r_op     <= w_head.op;
          r_data   <= w_head.data;
          r_mask   <= w_head.mask;
          gb_addr  <= w_head.addr;
          gb_wdata <= w_head.data;
          r_rdata  <= '0;
          r_err    <= 1'b0;
          r_to     <= 1'b0;
          if (w_head.op == OP_PL) r_tocnt <= '1;
          r_state  <= (w_head.op == OP_WR) ? S_WSTB : S_RSTB;
        end
        S_WSTB: begin
          gb_wen  <= 1'b1;
          r_state <= S_DONE;
        end
        S_RSTB: begin
          gb_rstb <= 1'b1;
          r_wait  <= WAIT_INIT;
          r_state <= (RD_LAT == 1) ? S_EVAL : S_RWAIT;
        end
        S_RWAIT: begin
          if (r_wait == '0) r_state <= S_EVAL;
          else              r_wait  <= r_wait - 3'd1;
        end
        S_EVAL: begin
          r_rdata <= gb_rdata;
          r_state <= S_DONE;
          case (r_op)
            OP_CK: r_err <= !w_match;
            OP_PL: begin
              // A match wins over an expired timeout in the same evaluation.
              if (!w_match) begin
                if (r_tocnt == '0) begin
                  r_err <= 1'b1;
                  r_to  <= 1'b1;
                end else begin
                  r_state <= S_RSTB;
                end
              end
            end
            default: r_err <= 1'b0;
          endcase
        end
        S_DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= r_rdata;
          rsp_err   <= r_err;
          rsp_to    <= r_to;
          if (r_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gb_host_seq.sv
// Self-checking bench for gb_host_seq: scoreboard of expected responses plus
// per-scenario latency, strobe and reset checks.
`timescale 1ns/1ps
module tb_gb_host_seq;
  localparam int AW = 24, DW = 32, RD_LAT = 2, TOW = 6, DEPTH = 4;

  logic          gb_clk = 1'b0;
  logic          gb_rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0, cmd_mask = '0;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata, gb_rdata;
  logic          gb_wen, gb_rstb, rsp_valid, rsp_err, rsp_to, busy;
  logic [DW-1:0] rsp_data;
  logic [15:0]   err_count;

  always #5 gb_clk = ~gb_clk;

  gb_host_seq #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .TOW(TOW), .DEPTH(DEPTH)) dut (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_wen(gb_wen), .gb_rstb(gb_rstb),
    .gb_rdata(gb_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_to(rsp_to), .busy(busy), .err_count(err_count)
  );

  // Bus model: either a fixed value or an address-derived pattern.
  logic          bus_mode = 1'b0;
  logic [DW-1:0] bus_val = '0;
  function automatic logic [DW-1:0] bus_fn(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction
  assign gb_rdata = bus_mode ? bus_fn(gb_addr) : bus_val;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          to;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_pass = 0, n_total = 0;
  int cyc = 0, push_cyc = 0, rsp_cyc = 0, wen_cyc = 0;
  int n_rsp = 0, n_wen = 0, n_rstb = 0;
  logic [AW-1:0] wen_addr;
  logic [DW-1:0] wen_data;

  always @(posedge gb_clk) cyc <= cyc + 1;

  always @(negedge gb_clk) begin
    if (gb_wen) begin
      n_wen++; wen_cyc = cyc; wen_addr = gb_addr; wen_data = gb_wdata;
    end
    if (gb_rstb) n_rstb++;
    if (gb_wen && gb_rstb) begin
      n_total++;
      $display("FAIL strobe_overlap: wen=%0b rstb=%0b, required not both high", gb_wen, gb_rstb);
    end
    if (rsp_valid) begin
      n_rsp++; rsp_cyc = cyc; n_total++;
      if (sb.size() == 0) begin
        $display("FAIL rsp_unexpected: data=%h err=%0b to=%0b, required no response", rsp_data, rsp_err, rsp_to);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_data !== mon_e.data || rsp_err !== mon_e.err || rsp_to !== mon_e.to)
          $display("FAIL rsp_scoreboard: got data=%h err=%0b to=%0b, required data=%h err=%0b to=%0b",
                   rsp_data, rsp_err, rsp_to, mon_e.data, mon_e.err, mon_e.to);
        else n_pass++;
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m, input logic [DW-1:0] ed, input logic ee, input logic et);
    int w = 0;
    while (!cmd_ready && w < 200) begin @(posedge gb_clk); #1; w++; end
    if (!cmd_ready) begin
      n_total++;
      $display("FAIL push_ready_timeout: cmd_ready=%0b, required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    sb.push_back('{data: ed, err: ee, to: et});
    @(posedge gb_clk); #1;
    push_cyc  = cyc;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(3, 0));
    cmd_addr  = AW'($urandom);
    cmd_data  = $urandom;
    cmd_mask  = $urandom;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int w = 0;
    while ((sb.size() != 0 || busy) && w < maxc) begin @(posedge gb_clk); #1; w++; end
    if (sb.size() != 0 || busy) begin
      n_total++;
      $display("FAIL %s_timeout: pending=%0d busy=%0b, required 0/0", nm, sb.size(), busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge gb_clk); #1;
    n_total++;
    if ({gb_addr, gb_wdata, gb_wen, gb_rstb, rsp_valid, rsp_data, rsp_err, rsp_to, err_count} !== '0)
      $display("FAIL reset_outputs: addr=%h wdata=%h wen=%0b rstb=%0b rv=%0b rd=%h cnt=%0d, required all 0",
               gb_addr, gb_wdata, gb_wen, gb_rstb, rsp_valid, rsp_data, err_count);
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0b, required 1", cmd_ready); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", busy); else n_pass++;
    gb_rst_n = 1'b1;
    @(posedge gb_clk); #1;
  endtask

  task automatic test_write;
    int w0 = n_wen;
    push(2'd0, 24'h000010, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_idle(50, "write");
    n_total++;
    if (n_wen - w0 != 1) $display("FAIL write_pulses: got %0d, required 1", n_wen - w0); else n_pass++;
    n_total++;
    if (wen_addr !== 24'h000010 || wen_data !== 32'hDEADBEEF)
      $display("FAIL write_bus: got addr=%h data=%h, required 000010/deadbeef", wen_addr, wen_data);
    else n_pass++;
    n_total++;
    if (wen_cyc - push_cyc != 2) $display("FAIL write_wen_lat: got %0d, required 2", wen_cyc - push_cyc); else n_pass++;
    n_total++;
    if (rsp_cyc - push_cyc != 3) $display("FAIL write_rsp_lat: got %0d, required 3", rsp_cyc - push_cyc); else n_pass++;
  endtask

  task automatic test_read;
    int r0 = n_rstb;
    bus_mode = 1'b1;
    push(2'd1, 24'h000123, 32'h0, 32'h0, bus_fn(24'h000123), 1'b0, 1'b0);
    wait_idle(50, "read");
    n_total++;
    if (rsp_cyc - push_cyc != 5) $display("FAIL read_rsp_lat: got %0d, required 5", rsp_cyc - push_cyc); else n_pass++;
    n_total++;
    if (n_rstb - r0 != 1) $display("FAIL read_pulses: got %0d, required 1", n_rstb - r0); else n_pass++;
  endtask

  task automatic test_check;
    bus_mode = 1'b0; bus_val = 32'hDEAD0000;
    push(2'd2, 24'h000010, 32'hDEADBEEF, 32'hFFFF0000, 32'hDEAD0000, 1'b0, 1'b0);
    wait_idle(50, "check_ok");
    n_total++;
    if (err_count !== 16'd0) $display("FAIL check_ok_cnt: got %0d, required 0", err_count); else n_pass++;
    bus_val = 32'h0EAD0000;
    push(2'd2, 24'h000010, 32'hDEADBEEF, 32'hFFFF0000, 32'h0EAD0000, 1'b1, 1'b0);
    wait_idle(50, "check_bad");
    n_total++;
    if (err_count !== 16'd1) $display("FAIL check_bad_cnt: got %0d, required 1", err_count); else n_pass++;
    repeat (3) @(posedge gb_clk); #1;
    n_total++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0EAD0000)
      $display("FAIL rsp_hold: got err=%0b data=%h, required 1/0ead0000", rsp_err, rsp_data);
    else n_pass++;
  endtask

  task automatic test_poll_match;
    int r0 = n_rstb;
    bus_mode = 1'b0; bus_val = 32'h0;
    push(2'd3, 24'h000020, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0);
    repeat (20) @(posedge gb_clk); #1;
    bus_val = 32'h1;
    wait_idle(100, "poll_match");
    n_total++;
    if (n_rstb - r0 < 2) $display("FAIL poll_repeat: got %0d reads, required >=2", n_rstb - r0); else n_pass++;
    n_total++;
    if (err_count !== 16'd1) $display("FAIL poll_match_cnt: got %0d, required 1", err_count); else n_pass++;
  endtask

  task automatic test_poll_timeout;
    bus_mode = 1'b0; bus_val = 32'h0;
    push(2'd3, 24'h000030, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1);
    wait_idle(200, "poll_to");
    n_total++;
    if (rsp_cyc - push_cyc > 63 + RD_LAT + 3 + 1 || rsp_cyc - push_cyc < 60)
      $display("FAIL poll_to_lat: got %0d, required 60..%0d", rsp_cyc - push_cyc, 63 + RD_LAT + 4);
    else n_pass++;
    n_total++;
    if (err_count !== 16'd2) $display("FAIL poll_to_cnt: got %0d, required 2", err_count); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n0 = n_rsp;
    bus_mode = 1'b1;
    push(2'd1, 24'h000100, 32'h0, 32'h0, bus_fn(24'h000100), 1'b0, 1'b0);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_early: got %0b, required 1", cmd_ready); else n_pass++;
    push(2'd2, 24'h000101, bus_fn(24'h000101), 32'hFFFFFFFF, bus_fn(24'h000101), 1'b0, 1'b0);
    push(2'd0, 24'h000102, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0);
    push(2'd1, 24'h000103, 32'h0, 32'h0, bus_fn(24'h000103), 1'b0, 1'b0);
    push(2'd2, 24'h000104, 32'h0, 32'h000000FF, bus_fn(24'h000104), 1'b1, 1'b0);
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL b2b_full: cmd_ready=%0b, required 0", cmd_ready); else n_pass++;
    push(2'd0, 24'h000105, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_idle(300, "b2b");
    n_total++;
    if (n_rsp - n0 != 6) $display("FAIL b2b_count: got %0d, required 6", n_rsp - n0); else n_pass++;
    n_total++;
    if (err_count !== 16'd3) $display("FAIL b2b_cnt: got %0d, required 3", err_count); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n0, w0;
    bus_mode = 1'b1;
    push(2'd1, 24'h000200, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    push(2'd1, 24'h000201, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    push(2'd0, 24'h000202, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    gb_rst_n = 1'b0;
    #1;
    sb.delete();
    n0 = n_rsp; w0 = n_wen;
    n_total++;
    if ({gb_addr, gb_wdata, gb_wen, gb_rstb, rsp_valid, rsp_data, rsp_err, rsp_to, err_count} !== '0)
      $display("FAIL abort_outputs: addr=%h wdata=%h wen=%0b rstb=%0b rv=%0b rd=%h cnt=%0d, required all 0",
               gb_addr, gb_wdata, gb_wen, gb_rstb, rsp_valid, rsp_data, err_count);
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_flags: ready=%0b busy=%0b, required 1/0", cmd_ready, busy);
    else n_pass++;
    repeat (3) @(posedge gb_clk); #1;
    gb_rst_n = 1'b1;
    repeat (6) @(posedge gb_clk); #1;
    n_total++;
    if (n_rsp != n0 || n_wen != w0)
      $display("FAIL abort_activity: rsp=%0d wen=%0d, required 0/0", n_rsp - n0, n_wen - w0);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %0b, required 0", busy); else n_pass++;
    push(2'd0, 24'h000300, 32'h55AA55AA, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_idle(50, "resume");
    n_total++;
    if (wen_addr !== 24'h000300 || wen_data !== 32'h55AA55AA)
      $display("FAIL resume_bus: got addr=%h data=%h, required 000300/55aa55aa", wen_addr, wen_data);
    else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_check();
    test_poll_match();
    test_poll_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
